// File: rtl/xcorr_shift_ctrl_pkg.sv
// Shared state encodings and magnitude helper for the CAF shift controller.
// The optional peak tracker is enabled with the CAF_PEAK_EN macro.
package xcorr_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ctrl_state_t;

  localparam int MAX_ABS_BITS = 64;

  // Callers sign-extend into the wide argument and truncate the result.
  function automatic logic [MAX_ABS_BITS-1:0] abs_mag(input logic signed [MAX_ABS_BITS-1:0] v);
    logic [MAX_ABS_BITS-1:0] r;
    r = v[MAX_ABS_BITS-1] ? MAX_ABS_BITS'(-v) : MAX_ABS_BITS'(v);
    return r;
  endfunction

endpackage

// File: rtl/xcorr_shift_ctrl_if.sv
// Buffer-read, dot-product-engine and result-stream signals of the shift controller.
// master = controller side, slave = buffers/engine/downstream side.
interface xcorr_shift_ctrl_if #(
  parameter int REF_ADDR_BITS = 3,
  parameter int RX_ADDR_BITS  = 4,
  parameter int I_BITS        = 24,
  parameter int Q_BITS        = 24,
  parameter int SHIFT_BITS    = 3
);

  logic                     ref_rd_en;
  logic [REF_ADDR_BITS-1:0] ref_addr;
  logic                     rx_rd_en;
  logic [RX_ADDR_BITS-1:0]  rx_addr;
  logic                     dp_x_tvalid;
  logic                     dp_y_tvalid;
  logic                     dp_product_tready;
  logic                     dp_product_tvalid;
  logic [I_BITS-1:0]        dp_i;
  logic [Q_BITS-1:0]        dp_q;
  logic                     out_tready;
  logic                     out_tvalid;
  logic [I_BITS-1:0]        out_i;
  logic [Q_BITS-1:0]        out_q;
  logic [SHIFT_BITS-1:0]    out_shift;

  modport master (
    output ref_rd_en, ref_addr, rx_rd_en, rx_addr,
    output dp_x_tvalid, dp_y_tvalid, dp_product_tready,
    input  dp_product_tvalid, dp_i, dp_q,
    input  out_tready,
    output out_tvalid, out_i, out_q, out_shift
  );

  modport slave (
    input  ref_rd_en, ref_addr, rx_rd_en, rx_addr,
    input  dp_x_tvalid, dp_y_tvalid, dp_product_tready,
    output dp_product_tvalid, dp_i, dp_q,
    output out_tready,
    input  out_tvalid, out_i, out_q, out_shift
  );

endinterface

// File: rtl/xcorr_shift_ctrl_peak_tracker.sv
// Tracks the largest |I|+|Q| result of a sweep and the shift that produced it.
// Only instantiated by xcorr_shift_ctrl when CAF_PEAK_EN is defined.
module xcorr_peak_tracker
  import xcorr_ctrl_pkg::*;
#(
  parameter int I_BITS     = 24,
  parameter int Q_BITS     = 24,
  parameter int SHIFT_BITS = 3,
  parameter int MAG_BITS   = 25
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_valid,
  input  logic [I_BITS-1:0]     i_i,
  input  logic [Q_BITS-1:0]     i_q,
  input  logic [SHIFT_BITS-1:0] i_shift,
  output logic [MAG_BITS-1:0]   o_peak_mag,
  output logic [SHIFT_BITS-1:0] o_peak_shift
);

  logic [MAG_BITS-1:0]   w_abs_i;
  logic [MAG_BITS-1:0]   w_abs_q;
  logic [MAG_BITS-1:0]   w_mag;
  logic [MAG_BITS-1:0]   r_peak_mag;
  logic [SHIFT_BITS-1:0] r_peak_shift;

  assign w_abs_i = MAG_BITS'(abs_mag(MAX_ABS_BITS'(signed'(i_i))));
  assign w_abs_q = MAG_BITS'(abs_mag(MAX_ABS_BITS'(signed'(i_q))));
  assign w_mag   = w_abs_i + w_abs_q;

  // Strict compare so a tie keeps the earlier shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_peak_mag   <= '0;
      r_peak_shift <= '0;
    end else if (i_clear) begin
      r_peak_mag   <= '0;
      r_peak_shift <= '0;
    end else if (i_valid && (w_mag > r_peak_mag)) begin
      r_peak_mag   <= w_mag;
      r_peak_shift <= i_shift;
    end
  end

  assign o_peak_mag   = r_peak_mag;
  assign o_peak_shift = r_peak_shift;

endmodule

// File: rtl/xcorr_shift_ctrl.sv
// Sweeps NUM_SHIFTS delay hypotheses through the complex dot-product engine and tags results.
// Define CAF_PEAK_EN to add the peak magnitude / peak shift outputs.
module xcorr_shift_ctrl
  import xcorr_ctrl_pkg::*;
#(
  parameter int LENGTH        = 5,
  parameter int LEN_CNT_BITS  = 3,
  parameter int NUM_SHIFTS    = 8,
  parameter int SHIFT_BITS    = 3,
  parameter int REF_ADDR_BITS = 3,
  parameter int RX_ADDR_BITS  = 4,
  parameter int I_BITS        = 24,
  parameter int Q_BITS        = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  output logic o_busy,
  output logic o_done,
`ifdef CAF_PEAK_EN
  output logic [((I_BITS > Q_BITS) ? I_BITS : Q_BITS):0] o_peak_mag,
  output logic [SHIFT_BITS-1:0]                          o_peak_shift,
`endif
  xcorr_shift_ctrl_if.master bus
);

  localparam int CNT_BITS = SHIFT_BITS + 1;
  localparam logic [LEN_CNT_BITS-1:0] K_LAST   = LEN_CNT_BITS'(LENGTH - 1);
  localparam logic [SHIFT_BITS-1:0]   S_LAST   = SHIFT_BITS'(NUM_SHIFTS - 1);
  localparam logic [CNT_BITS-1:0]     CNT_DONE = CNT_BITS'(NUM_SHIFTS);

  ctrl_state_t              r_state;
  logic [LEN_CNT_BITS-1:0]  r_k;
  logic [SHIFT_BITS-1:0]    r_s;
  logic [CNT_BITS-1:0]      r_result_cnt;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_rd_en;
  logic [REF_ADDR_BITS-1:0] r_ref_addr;
  logic [RX_ADDR_BITS-1:0]  r_rx_addr;
  logic                     r_dp_tvalid;
  logic                     r_tvalid_q;
  logic                     r_out_tvalid;
  logic [I_BITS-1:0]        r_out_i;
  logic [Q_BITS-1:0]        r_out_q;
  logic [SHIFT_BITS-1:0]    r_out_shift;

  logic                     w_accept;
  logic                     w_last_read;
  logic                     w_product_edge;
  logic [RX_ADDR_BITS-1:0]  w_rx_addr;

  assign w_accept       = (r_state == ST_IDLE) && i_start;
  assign w_last_read    = (r_s == S_LAST) && (r_k == K_LAST);
  assign w_product_edge = bus.dp_product_tvalid && !r_tvalid_q;
  assign w_rx_addr      = RX_ADDR_BITS'(r_s) + RX_ADDR_BITS'(r_k);

  // Read sequencing: one buffer read per unstalled ISSUE cycle, k inner loop, s outer loop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_k        <= '0;
      r_s        <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_en    <= 1'b0;
      r_ref_addr <= '0;
      r_rx_addr  <= '0;
    end else begin
      r_rd_en <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_ISSUE;
            r_k     <= '0;
            r_s     <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (bus.out_tready) begin
            r_rd_en    <= 1'b1;
            r_ref_addr <= REF_ADDR_BITS'(r_k);
            r_rx_addr  <= w_rx_addr;
            if (r_k == K_LAST) begin
              r_k <= '0;
              r_s <= r_s + 1'b1;
            end else begin
              r_k <= r_k + 1'b1;
            end
            if (w_last_read) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (r_result_cnt == CNT_DONE) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // The engine may hold tvalid through a stall, so only its rising edge marks a new result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dp_tvalid  <= 1'b0;
      r_tvalid_q   <= 1'b0;
      r_out_tvalid <= 1'b0;
      r_out_i      <= '0;
      r_out_q      <= '0;
      r_out_shift  <= '0;
      r_result_cnt <= '0;
    end else begin
      r_dp_tvalid  <= r_rd_en;
      r_tvalid_q   <= bus.dp_product_tvalid;
      r_out_tvalid <= 1'b0;
      if (w_accept) begin
        r_result_cnt <= '0;
      end else if (w_product_edge && (r_state != ST_IDLE)) begin
        r_out_tvalid <= 1'b1;
        r_out_i      <= bus.dp_i;
        r_out_q      <= bus.dp_q;
        r_out_shift  <= SHIFT_BITS'(r_result_cnt);
        r_result_cnt <= r_result_cnt + 1'b1;
      end
    end
  end

  assign o_busy                = r_busy;
  assign o_done                = r_done;
  assign bus.ref_rd_en         = r_rd_en;
  assign bus.rx_rd_en          = r_rd_en;
  assign bus.ref_addr          = r_ref_addr;
  assign bus.rx_addr           = r_rx_addr;
  assign bus.dp_x_tvalid       = r_dp_tvalid;
  assign bus.dp_y_tvalid       = r_dp_tvalid;
  assign bus.dp_product_tready = bus.out_tready;
  assign bus.out_tvalid        = r_out_tvalid;
  assign bus.out_i             = r_out_i;
  assign bus.out_q             = r_out_q;
  assign bus.out_shift         = r_out_shift;

`ifdef CAF_PEAK_EN
  localparam int MAG_BITS = ((I_BITS > Q_BITS) ? I_BITS : Q_BITS) + 1;

  xcorr_peak_tracker #(
    .I_BITS     (I_BITS),
    .Q_BITS     (Q_BITS),
    .SHIFT_BITS (SHIFT_BITS),
    .MAG_BITS   (MAG_BITS)
  ) u_peak (
    .clk          (clk),
    .rst          (rst),
    .i_clear      (w_accept),
    .i_valid      (r_out_tvalid),
    .i_i          (r_out_i),
    .i_q          (r_out_q),
    .i_shift      (r_out_shift),
    .o_peak_mag   (o_peak_mag),
    .o_peak_shift (o_peak_shift)
  );
`endif

endmodule

// File: tb/tb_xcorr_shift_ctrl.sv
// Directed bench for xcorr_shift_ctrl with behavioural sample buffers and dot-product engine.
// The peak-tracker scenario is compiled in only when CAF_PEAK_EN is defined.
module tb_xcorr_shift_ctrl;

  localparam int LENGTH     = 5;
  localparam int NUM_SHIFTS = 4;
  localparam int NREADS     = LENGTH * NUM_SHIFTS;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;
  logic tready;
`ifdef CAF_PEAK_EN
  logic [24:0] peak_mag;
  logic [2:0]  peak_shift;
`endif

  int checks = 0;
  int errors = 0;

  xcorr_shift_ctrl_if #(
    .REF_ADDR_BITS(3), .RX_ADDR_BITS(4), .I_BITS(24), .Q_BITS(24), .SHIFT_BITS(3)
  ) bus ();

  xcorr_shift_ctrl #(
    .LENGTH(LENGTH), .LEN_CNT_BITS(3), .NUM_SHIFTS(NUM_SHIFTS), .SHIFT_BITS(3),
    .REF_ADDR_BITS(3), .RX_ADDR_BITS(4), .I_BITS(24), .Q_BITS(24)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_start (start),
    .o_busy  (busy),
    .o_done  (done),
`ifdef CAF_PEAK_EN
    .o_peak_mag   (peak_mag),
    .o_peak_shift (peak_shift),
`endif
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Sample buffers with one-cycle read latency: ref = (1,0), rx[n] = (n,0)
  int ref_mem_i [8];
  int ref_mem_q [8];
  int rx_mem_i [16];
  int rx_mem_q [16];
  int ref_di, ref_dq, rx_di, rx_dq;

  always @(posedge clk) begin
    if (bus.ref_rd_en) begin
      ref_di <= ref_mem_i[bus.ref_addr];
      ref_dq <= ref_mem_q[bus.ref_addr];
    end
    if (bus.rx_rd_en) begin
      rx_di <= rx_mem_i[bus.rx_addr];
      rx_dq <= rx_mem_q[bus.rx_addr];
    end
  end

  // Engine: accumulates every valid sample pair, holds product valid while tready is low
  bit   use_table;
  int   tbl_i [4];
  int   tbl_q [4];
  int   acc_i, acc_q, eng_cnt, tbl_idx;
  logic prod_valid;
  logic [23:0] prod_i, prod_q;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_i <= 0; acc_q <= 0; eng_cnt <= 0; tbl_idx <= 0;
      prod_valid <= 1'b0; prod_i <= '0; prod_q <= '0;
    end else if (bus.dp_x_tvalid && bus.dp_y_tvalid && eng_cnt == LENGTH - 1) begin
      prod_valid <= 1'b1;
      if (use_table) begin
        prod_i <= 24'(tbl_i[tbl_idx % 4]);
        prod_q <= 24'(tbl_q[tbl_idx % 4]);
      end else begin
        prod_i <= 24'(acc_i + ref_di * rx_di - ref_dq * rx_dq);
        prod_q <= 24'(acc_q + ref_di * rx_dq + ref_dq * rx_di);
      end
      acc_i <= 0; acc_q <= 0; eng_cnt <= 0; tbl_idx <= tbl_idx + 1;
    end else begin
      if (bus.dp_x_tvalid && bus.dp_y_tvalid) begin
        acc_i   <= acc_i + ref_di * rx_di - ref_dq * rx_dq;
        acc_q   <= acc_q + ref_di * rx_dq + ref_dq * rx_di;
        eng_cnt <= eng_cnt + 1;
      end
      if (bus.dp_product_tready) prod_valid <= 1'b0;
    end
  end

  assign bus.dp_product_tvalid = prod_valid;
  assign bus.dp_i              = prod_i;
  assign bus.dp_q              = prod_q;
  assign bus.out_tready        = tready;

  // Per-sweep observations gathered by run_sweep
  int rd_ref [64];
  int rd_rx [64];
  int n_reads;
  int res_i [16];
  int res_q [16];
  int res_shift [16];
  int n_out, n_done, busy_err, xv_err, pair_err, tready_err, stall_rd_err, stall_addr_err;
  bit timed_out, stall_hit;

  task automatic run_sweep(input bit do_stall, input bit extra_start);
    int   cyc;
    bit   seen_done;
    bit   stall_armed;
    int   stall_left;
    logic prev_rd, prev_tready;
    logic [2:0] prev_ref;
    logic [3:0] prev_rx;
    n_reads = 0; n_out = 0; n_done = 0; busy_err = 0; xv_err = 0; pair_err = 0;
    tready_err = 0; stall_rd_err = 0; stall_addr_err = 0; stall_hit = 0;
    stall_armed = do_stall; stall_left = 0; seen_done = 0; cyc = 0;
    @(negedge clk);
    prev_rd = bus.ref_rd_en; prev_tready = tready;
    prev_ref = bus.ref_addr; prev_rx = bus.rx_addr;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!seen_done && cyc < 400) begin
      start = (extra_start && cyc == 6);
      @(negedge clk);
      cyc++;
      if (bus.dp_x_tvalid !== prev_rd || bus.dp_y_tvalid !== prev_rd) xv_err++;
      if (bus.ref_rd_en !== bus.rx_rd_en) pair_err++;
      if (bus.dp_product_tready !== tready) tready_err++;
      if (prev_tready == 1'b0) begin
        if (bus.ref_rd_en !== 1'b0) stall_rd_err++;
        if (bus.ref_addr !== prev_ref || bus.rx_addr !== prev_rx) stall_addr_err++;
      end
      if (bus.ref_rd_en === 1'b1) begin
        if (n_reads < 64) begin
          rd_ref[n_reads] = int'(bus.ref_addr);
          rd_rx[n_reads]  = int'(bus.rx_addr);
        end
        n_reads++;
      end
      if (bus.out_tvalid === 1'b1) begin
        if (n_out < 16) begin
          res_i[n_out]     = int'($signed(bus.out_i));
          res_q[n_out]     = int'($signed(bus.out_q));
          res_shift[n_out] = int'(bus.out_shift);
        end
        n_out++;
      end
      if (done === 1'b1) begin
        n_done++;
        if (busy !== 1'b0) busy_err++;
        seen_done = 1;
      end
      prev_rd = bus.ref_rd_en; prev_ref = bus.ref_addr; prev_rx = bus.rx_addr;
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) tready = 1'b1;
      end else if (stall_armed && bus.dp_product_tvalid === 1'b1) begin
        tready = 1'b0;
        stall_left = 3;
        stall_armed = 0;
        stall_hit = 1;
      end
      prev_tready = tready;
    end
    start = 1'b0;
    tready = 1'b1;
    timed_out = !seen_done;
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (bus.ref_rd_en !== 1'b0 || bus.rx_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_en: got %b/%b expected 0/0", bus.ref_rd_en, bus.rx_rd_en); end
    checks++; if (bus.dp_x_tvalid !== 1'b0 || bus.dp_y_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_dp_tvalid: got %b/%b expected 0/0", bus.dp_x_tvalid, bus.dp_y_tvalid); end
    checks++; if (bus.out_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_tvalid: got %b expected 0", bus.out_tvalid); end
    checks++; if (bus.out_i !== 24'd0 || bus.out_q !== 24'd0) begin errors++; $display("[TB] FAIL reset_out_iq: got %0d/%0d expected 0/0", bus.out_i, bus.out_q); end
    checks++; if (bus.out_shift !== 3'd0) begin errors++; $display("[TB] FAIL reset_out_shift: got %0d expected 0", bus.out_shift); end
    checks++; if (bus.ref_addr !== 3'd0 || bus.rx_addr !== 4'd0) begin errors++; $display("[TB] FAIL reset_addr: got %0d/%0d expected 0/0", bus.ref_addr, bus.rx_addr); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || bus.ref_rd_en !== 1'b0) begin errors++; $display("[TB] FAIL idle_after_reset: got busy=%b rd=%b expected 0/0", busy, bus.ref_rd_en); end
  endtask

  task automatic test_basic_sweep();
    run_sweep(1'b0, 1'b0);
    checks++; if (timed_out) begin errors++; $display("[TB] FAIL basic_done_seen: got timeout expected done"); end
    checks++; if (n_reads != NREADS) begin errors++; $display("[TB] FAIL basic_read_count: got %0d expected %0d", n_reads, NREADS); end
    for (int j = 0; j < NREADS && j < n_reads; j++) begin
      checks++;
      if (rd_ref[j] != j % LENGTH || rd_rx[j] != j / LENGTH + j % LENGTH) begin
        errors++;
        $display("[TB] FAIL basic_read_addr[%0d]: got ref=%0d rx=%0d expected ref=%0d rx=%0d", j, rd_ref[j], rd_rx[j], j % LENGTH, j / LENGTH + j % LENGTH);
      end
    end
    checks++; if (n_out != NUM_SHIFTS) begin errors++; $display("[TB] FAIL basic_result_count: got %0d expected %0d", n_out, NUM_SHIFTS); end
    for (int s = 0; s < NUM_SHIFTS && s < n_out; s++) begin
      checks++;
      if (res_i[s] != 10 + 5 * s || res_q[s] != 0 || res_shift[s] != s) begin
        errors++;
        $display("[TB] FAIL basic_result[%0d]: got i=%0d q=%0d shift=%0d expected i=%0d q=0 shift=%0d", s, res_i[s], res_q[s], res_shift[s], 10 + 5 * s, s);
      end
    end
    checks++; if (n_done != 1) begin errors++; $display("[TB] FAIL basic_done_count: got %0d expected 1", n_done); end
    checks++; if (busy_err != 0) begin errors++; $display("[TB] FAIL basic_busy_with_done: got %0d busy cycles expected 0", busy_err); end
    checks++; if (xv_err != 0) begin errors++; $display("[TB] FAIL basic_dp_tvalid_lag: got %0d bad cycles expected 0", xv_err); end
    checks++; if (pair_err != 0) begin errors++; $display("[TB] FAIL basic_rd_en_pair: got %0d bad cycles expected 0", pair_err); end
    checks++; if (tready_err != 0) begin errors++; $display("[TB] FAIL basic_product_tready: got %0d bad cycles expected 0", tready_err); end
  endtask

  task automatic test_stall();
    run_sweep(1'b1, 1'b0);
    checks++; if (!stall_hit || timed_out) begin errors++; $display("[TB] FAIL stall_ran: got hit=%0d timeout=%0d expected 1/0", stall_hit, timed_out); end
    checks++; if (stall_rd_err != 0) begin errors++; $display("[TB] FAIL stall_rd_en_low: got %0d reads while stalled expected 0", stall_rd_err); end
    checks++; if (stall_addr_err != 0) begin errors++; $display("[TB] FAIL stall_addr_hold: got %0d address changes expected 0", stall_addr_err); end
    checks++; if (tready_err != 0) begin errors++; $display("[TB] FAIL stall_product_tready: got %0d bad cycles expected 0", tready_err); end
    checks++; if (n_reads != NREADS) begin errors++; $display("[TB] FAIL stall_read_count: got %0d expected %0d", n_reads, NREADS); end
    for (int j = 0; j < NREADS && j < n_reads; j++) begin
      checks++;
      if (rd_ref[j] != j % LENGTH || rd_rx[j] != j / LENGTH + j % LENGTH) begin
        errors++;
        $display("[TB] FAIL stall_read_addr[%0d]: got ref=%0d rx=%0d expected ref=%0d rx=%0d", j, rd_ref[j], rd_rx[j], j % LENGTH, j / LENGTH + j % LENGTH);
      end
    end
    checks++; if (n_out != NUM_SHIFTS) begin errors++; $display("[TB] FAIL stall_result_count: got %0d expected %0d", n_out, NUM_SHIFTS); end
    for (int s = 0; s < NUM_SHIFTS && s < n_out; s++) begin
      checks++;
      if (res_i[s] != 10 + 5 * s || res_q[s] != 0 || res_shift[s] != s) begin
        errors++;
        $display("[TB] FAIL stall_result[%0d]: got i=%0d q=%0d shift=%0d expected i=%0d q=0 shift=%0d", s, res_i[s], res_q[s], res_shift[s], 10 + 5 * s, s);
      end
    end
  endtask

  task automatic test_start_while_busy();
    run_sweep(1'b0, 1'b1);
    checks++; if (n_reads != NREADS) begin errors++; $display("[TB] FAIL busy_start_reads: got %0d expected %0d", n_reads, NREADS); end
    checks++; if (n_out != NUM_SHIFTS) begin errors++; $display("[TB] FAIL busy_start_results: got %0d expected %0d", n_out, NUM_SHIFTS); end
    checks++; if (n_out > 3 && (res_shift[3] != 3 || res_i[3] != 25)) begin errors++; $display("[TB] FAIL busy_start_last: got shift=%0d i=%0d expected 3/25", res_shift[3], res_i[3]); end
  endtask

  task automatic test_back_to_back();
    int  cyc;
    bit  got;
    run_sweep(1'b0, 1'b0);
    checks++; if (timed_out || n_out != NUM_SHIFTS) begin errors++; $display("[TB] FAIL b2b_first_sweep: got timeout=%0d results=%0d expected 0/%0d", timed_out, n_out, NUM_SHIFTS); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_start_on_done_ignored: got busy=%b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done_one_cycle: got done=%b expected 0", done); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_start_in_idle: got busy=%b expected 1", busy); end
    cyc = 0; got = 0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) got = 1;
    end
    checks++; if (!got) begin errors++; $display("[TB] FAIL b2b_second_done: got timeout expected done"); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit got;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; got = 0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.out_tvalid === 1'b1) got = 1;
    end
    checks++; if (!got || bus.out_i !== 24'd10) begin errors++; $display("[TB] FAIL rstmid_first_result: got seen=%0d i=%0d expected 1/10", got, bus.out_i); end
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (bus.ref_rd_en !== 1'b0 || bus.dp_x_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_rd: got rd=%b xv=%b expected 0/0", bus.ref_rd_en, bus.dp_x_tvalid); end
    checks++; if (bus.out_i !== 24'd0 || bus.out_shift !== 3'd0 || bus.out_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_out: got i=%0d shift=%0d v=%b expected 0/0/0", bus.out_i, bus.out_shift, bus.out_tvalid); end
    @(negedge clk);
    rst = 1'b0;
    run_sweep(1'b0, 1'b0);
    checks++; if (n_reads != NREADS || n_out != NUM_SHIFTS) begin errors++; $display("[TB] FAIL rstmid_clean_sweep: got reads=%0d results=%0d expected %0d/%0d", n_reads, n_out, NREADS, NUM_SHIFTS); end
    for (int s = 0; s < NUM_SHIFTS && s < n_out; s++) begin
      checks++;
      if (res_i[s] != 10 + 5 * s || res_shift[s] != s) begin
        errors++;
        $display("[TB] FAIL rstmid_result[%0d]: got i=%0d shift=%0d expected %0d/%0d", s, res_i[s], res_shift[s], 10 + 5 * s, s);
      end
    end
  endtask

`ifdef CAF_PEAK_EN
  task automatic test_peak();
    @(negedge clk);
    rst = 1'b1;
    use_table = 1;
    tbl_i[0] = 3;  tbl_q[0] = -4;
    tbl_i[1] = -7; tbl_q[1] = 1;
    tbl_i[2] = 2;  tbl_q[2] = 6;
    tbl_i[3] = 8;  tbl_q[3] = 0;
    @(negedge clk);
    rst = 1'b0;
    run_sweep(1'b0, 1'b0);
    checks++; if (n_out != 4 || res_i[1] != -7 || res_q[0] != -4) begin errors++; $display("[TB] FAIL peak_results: got n=%0d i1=%0d q0=%0d expected 4/-7/-4", n_out, res_i[1], res_q[0]); end
    checks++; if (peak_mag !== 25'd8) begin errors++; $display("[TB] FAIL peak_mag: got %0d expected 8", peak_mag); end
    checks++; if (peak_shift !== 3'd1) begin errors++; $display("[TB] FAIL peak_shift: got %0d expected 1", peak_shift); end
    use_table = 0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    start = 1'b0;
    tready = 1'b1;
    use_table = 0;
    for (int n = 0; n < 8; n++) begin ref_mem_i[n] = 1; ref_mem_q[n] = 0; end
    for (int n = 0; n < 16; n++) begin rx_mem_i[n] = n; rx_mem_q[n] = 0; end
    for (int n = 0; n < 4; n++) begin tbl_i[n] = 0; tbl_q[n] = 0; end
    repeat (3) @(negedge clk);
    test_reset();
    test_basic_sweep();
    test_stall();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
`ifdef CAF_PEAK_EN
    test_peak();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
